// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status, arbiter FSM states, word type and the
// value returned for accesses that never completed cleanly.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam word_t BADWORD         = 32'hBAD1BAD1;
  localparam int    TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU-facing and RAM-facing arbiter signals.
// Handshake: a requester raises iREN/dREN/dWEN and holds it until the
// matching one-cycle hit; it drops or changes the request the next cycle.
interface ram_arbiter_if import cpu_types_pkg::*; ();

  logic      iREN, ihit, dREN, dWEN, dhit, stall, err;
  logic      ramREN, ramWEN;
  word_t     iaddr, iload, daddr, dstore, dload;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport cpu (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, ihit, dload, dhit, stall, err
  );

  modport ram (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, stall, err,
    output ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter_timer.sv
// Access cycle counter: cleared while no access is in flight, counts each
// access cycle, flags the last cycle an access may wait for the RAM.
module arb_timer import cpu_types_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Serializes instruction fetches and data accesses onto one RAM port and
// returns one-cycle hit pulses with registered load data.
module ram_arbiter import cpu_types_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        stall,
  output logic        err,
  output logic [1:0]  dbg_state
);

  arb_state_t state_q, state_d;
  logic       write_q, write_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  word_t      iload_q, iload_d;
  word_t      dload_q, dload_d;
  logic       ihit_q, ihit_d;
  logic       dhit_q, dhit_d;
  logic       err_q, err_d;

  ramstate_t  ram_st;
  logic       in_access;
  logic       timer_expired;
  logic       finish;
  logic       faulted;
  word_t      resp_word;

  assign ram_st    = ramstate_t'(ramstate);
  assign in_access = (state_q == DATA) || (state_q == INSTR);

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (!in_access),
    .en      (in_access),
    .expired (timer_expired)
  );

  // ACCESS wins over an expiring counter on the same cycle.
  assign faulted   = (ram_st != ACCESS) && ((ram_st == ERROR) || timer_expired);
  assign finish    = in_access && ((ram_st == ACCESS) || faulted);
  assign resp_word = faulted ? BADWORD : (write_q ? '0 : ramload);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Data first: it belongs to the instruction already in flight.
        if (dREN || dWEN) begin
          write_d = dWEN;
          addr_d  = daddr;
          store_d = dWEN ? dstore : '0;
          state_d = DATA;
        end else if (iREN) begin
          write_d = 1'b0;
          addr_d  = iaddr;
          store_d = '0;
          state_d = INSTR;
        end
      end
      DATA, INSTR: begin
        if (finish) begin
          if (state_q == DATA) begin
            dload_d = resp_word;
            dhit_d  = 1'b1;
          end else begin
            iload_d = resp_word;
            ihit_d  = 1'b1;
          end
          if (faulted) begin
            err_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      err_q   <= err_d;
    end
  end

  assign ramREN    = (state_q == INSTR) || ((state_q == DATA) && !write_q);
  assign ramWEN    = (state_q == DATA) && write_q;
  assign ramaddr   = addr_q;
  assign ramstore  = store_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign err       = err_q;
  assign stall     = iREN && !ihit_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// single-side traffic against a transaction-level reference memory.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = 32'h0;
  logic [1:0]  ramstate = 2'b00;
  logic        ihit, dhit, ramREN, ramWEN, stall, err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .stall(stall), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  // mode 0: BUSY for ram_n cycles then ACCESS; 1: BUSY ram_n then ERROR; 2: BUSY forever
  int    ram_mode = 0;
  int    ram_n = 0;
  int    ram_cyc = 0;
  word_t mem [word_t];

  always @(negedge CLK) begin
    if (ramREN === 1'b1 || ramWEN === 1'b1) begin
      if (ram_mode == 2 || ram_cyc < ram_n) begin
        ramstate = 2'(BUSY);
        ramload  = $urandom;
      end else if (ram_mode == 1) begin
        ramstate = 2'(ERROR);
        ramload  = $urandom;
      end else begin
        ramstate = 2'(ACCESS);
        if (ramWEN) begin
          mem[ramaddr] = ramstore;
          ramload = $urandom;
        end else begin
          ramload = mem.exists(ramaddr) ? mem[ramaddr] : 32'h0;
        end
      end
      ram_cyc++;
    end else begin
      ramstate = 2'(FREE);
      ramload  = 32'h0;
      ram_cyc  = 0;
    end
  end

  // ---------------- reference model ----------------
  word_t ref_mem [word_t];
  word_t exp_q[$];
  bit    exp_err = 0;

  function automatic int exp_latency(int mode, int n);
    if (mode == 2 || n >= TO) return TO + 2;
    return 3 + n;
  endfunction

  function automatic bit exp_fault(int mode, int n);
    return (mode != 0) || (n >= TO);
  endfunction

  // ---------------- driver ----------------
  int    d_lat, i_lat, addr_bad, store_bad, wen_cyc, ren_cyc, extra_hit;
  word_t d_val, i_val;
  bit    timed_out;
  bit    stall_h[$];

  task automatic run_txn(input bit want_i, input bit want_d, input bit wr,
                         input word_t ia, input word_t da, input word_t wd);
    bit i_done, d_done;
    int cyc;
    d_lat = 0; i_lat = 0; d_val = '0; i_val = '0;
    addr_bad = 0; store_bad = 0; wen_cyc = 0; ren_cyc = 0; extra_hit = 0;
    timed_out = 0;
    stall_h.delete();
    i_done = !want_i;
    d_done = !want_d;
    @(posedge CLK); #1;
    iREN = want_i; iaddr = ia;
    dREN = want_d & !wr; dWEN = want_d & wr; daddr = da; dstore = wd;
    cyc = 0;
    while (!(i_done && d_done)) begin
      @(negedge CLK);
      cyc++;
      stall_h.push_back(stall);
      if (ramREN || ramWEN) begin
        if (ramREN) ren_cyc++;
        if (ramWEN) wen_cyc++;
        if (ramaddr !== (!d_done ? da : ia)) addr_bad++;
        if (ramWEN && ramstore !== wd) store_bad++;
      end
      if (dhit) begin
        if (d_done) extra_hit++;
        else begin d_done = 1; d_lat = cyc; d_val = dload; end
      end
      if (ihit) begin
        if (i_done) extra_hit++;
        else begin i_done = 1; i_lat = cyc; i_val = iload; end
      end
      @(posedge CLK); #1;
      if (d_done) begin dREN = 0; dWEN = 0; end
      if (i_done) iREN = 0;
      if (cyc > 200) begin timed_out = 1; break; end
    end
    iREN = 0; dREN = 0; dWEN = 0;
    @(negedge CLK);
    if (dhit || ihit) extra_hit++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rst_ramaddr got=%h exp=0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin failures++; $display("FAIL rst_ramstore got=%h exp=0", ramstore); end
    checks++; if (iload !== 32'h0 || dload !== 32'h0) begin failures++; $display("FAIL rst_loads got=%h/%h exp=0", iload, dload); end
    checks++; if ({ihit, dhit, ramREN, ramWEN, err, stall} !== 6'b0) begin failures++; $display("FAIL rst_flags got=%b exp=000000", {ihit, dhit, ramREN, ramWEN, err, stall}); end
    checks++; if (dbg_state !== 2'b00) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    nRST = 1;
  endtask

  task automatic test_ifetch;
    mem[32'h40] = 32'h8C010004;
    ram_mode = 0; ram_n = 0;
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0);
    checks++; if (timed_out) begin failures++; $display("FAIL ifetch_wait got=timeout exp=ihit"); end
    checks++; if (i_lat !== 3) begin failures++; $display("FAIL ifetch_lat got=%0d exp=3", i_lat); end
    checks++; if (i_val !== 32'h8C010004) begin failures++; $display("FAIL ifetch_data got=%h exp=8c010004", i_val); end
    checks++; if (stall_h.size() !== 3 || stall_h[0] !== 1'b1 || stall_h[1] !== 1'b1 || stall_h[2] !== 1'b0)
      begin failures++; $display("FAIL ifetch_stall got=%p exp=110", stall_h); end
    checks++; if (ren_cyc !== 1 || addr_bad !== 0) begin failures++; $display("FAIL ifetch_ram got ren=%0d badaddr=%0d exp 1/0", ren_cyc, addr_bad); end
    checks++; if (extra_hit !== 0) begin failures++; $display("FAIL ifetch_pulse got extra=%0d exp=0", extra_hit); end
  endtask

  task automatic test_data_priority;
    int sbad;
    mem[32'h100] = 32'h1234;
    mem[32'h44]  = 32'h20000001;
    ram_mode = 0; ram_n = 0;
    run_txn(1, 1, 0, 32'h44, 32'h100, 32'h0);
    checks++; if (d_lat !== 3 || d_val !== 32'h1234) begin failures++; $display("FAIL prio_data got lat=%0d val=%h exp 3/1234", d_lat, d_val); end
    checks++; if (i_lat !== 6 || i_val !== 32'h20000001) begin failures++; $display("FAIL prio_instr got lat=%0d val=%h exp 6/20000001", i_lat, i_val); end
    checks++; if (addr_bad !== 0) begin failures++; $display("FAIL prio_addr got bad=%0d exp=0", addr_bad); end
    sbad = 0;
    foreach (stall_h[k]) if (stall_h[k] !== (k < 5)) sbad++;
    checks++; if (sbad !== 0 || stall_h.size() !== 6) begin failures++; $display("FAIL prio_stall got=%p exp=111110", stall_h); end
  endtask

  task automatic test_write_busy;
    int sones;
    ram_mode = 0; ram_n = 3;
    run_txn(0, 1, 1, 32'h0, 32'h200, 32'hDEADBEEF);
    checks++; if (wen_cyc !== 4 || ren_cyc !== 0) begin failures++; $display("FAIL wr_enables got wen=%0d ren=%0d exp 4/0", wen_cyc, ren_cyc); end
    checks++; if (store_bad !== 0 || addr_bad !== 0) begin failures++; $display("FAIL wr_bus got storebad=%0d addrbad=%0d exp 0/0", store_bad, addr_bad); end
    checks++; if (d_lat !== 6 || d_val !== 32'h0) begin failures++; $display("FAIL wr_hit got lat=%0d val=%h exp 6/0", d_lat, d_val); end
    checks++; if (!mem.exists(32'h200) || mem[32'h200] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_mem got=%h exp=deadbeef", mem.exists(32'h200) ? mem[32'h200] : 32'h0); end
    sones = 0;
    foreach (stall_h[k]) if (stall_h[k]) sones++;
    checks++; if (sones !== 0 || err !== 1'b0) begin failures++; $display("FAIL wr_side got stall_hi=%0d err=%b exp 0/0", sones, err); end
  endtask

  task automatic test_error_beat;
    ram_mode = 1; ram_n = 1;
    run_txn(0, 1, 0, 32'h0, 32'h104, 32'h0);
    checks++; if (d_lat !== 4 || d_val !== BADWORD) begin failures++; $display("FAIL err_hit got lat=%0d val=%h exp 4/%h", d_lat, d_val, BADWORD); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", err); end
  endtask

  task automatic test_timeout;
    ram_mode = 2; ram_n = 0;
    run_txn(1, 0, 0, 32'h48, 32'h0, 32'h0);
    checks++; if (i_lat !== TO + 2 || i_val !== BADWORD) begin failures++; $display("FAIL to_hit got lat=%0d val=%h exp %0d/%h", i_lat, i_val, TO + 2, BADWORD); end
    checks++; if (ren_cyc !== TO || err !== 1'b1) begin failures++; $display("FAIL to_state got ren=%0d err=%b exp %0d/1", ren_cyc, err, TO); end
    ram_mode = 0; ram_n = 0;
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0);
    checks++; if (i_val !== 32'h8C010004 || err !== 1'b1) begin failures++; $display("FAIL to_sticky got val=%h err=%b exp 8c010004/1", i_val, err); end
  endtask

  task automatic test_reset_mid_access;
    int hit_at;
    ram_mode = 2;
    @(posedge CLK); #1;
    dREN = 1; daddr = 32'h300;
    repeat (3) @(posedge CLK);
    #2 nRST = 0;
    #1;
    checks++; if ({ramREN, ramWEN, dhit, ihit, err} !== 5'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=00000", {ramREN, ramWEN, dhit, ihit, err}); end
    checks++; if (ramaddr !== 32'h0 || dload !== 32'h0 || iload !== 32'h0) begin failures++; $display("FAIL midrst_words got addr=%h dload=%h iload=%h exp 0", ramaddr, dload, iload); end
    mem[32'h300] = 32'h5555AAAA;
    ram_mode = 0; ram_n = 0;
    @(negedge CLK);
    nRST = 1;
    hit_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (dhit && hit_at == 0) hit_at = k;
      if (hit_at != 0) break;
    end
    checks++; if (hit_at !== 2 || dload !== 32'h5555AAAA) begin failures++; $display("FAIL midrst_reissue got hit_at=%0d dload=%h exp 2/5555aaaa", hit_at, dload); end
    @(posedge CLK); #1;
    dREN = 0;
    @(negedge CLK);
    checks++; if (dhit !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midrst_after got dhit=%b err=%b exp 0/0", dhit, err); end
  endtask

  task automatic test_random;
    bit    is_d, wr, flt;
    word_t a, wd, exp_v, got_v;
    int    r, lat, got_lat;
    exp_err = 0;
    for (int t = 0; t < 40; t++) begin
      is_d = $urandom_range(0, 1);
      wr   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a    = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      wd   = $urandom;
      r    = $urandom_range(0, 9);
      if (r < 7)       begin ram_mode = 0; ram_n = $urandom_range(0, 3); end
      else if (r == 7) begin ram_mode = 1; ram_n = $urandom_range(0, 2); end
      else if (r == 8) begin ram_mode = 0; ram_n = $urandom_range(TO, TO + 3); end
      else             begin ram_mode = 2; ram_n = 0; end
      lat = exp_latency(ram_mode, ram_n);
      flt = exp_fault(ram_mode, ram_n);
      if (flt) exp_v = BADWORD;
      else if (wr) exp_v = 32'h0;
      else exp_v = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      if (wr && !flt) ref_mem[a] = wd;
      exp_err = exp_err | flt;
      exp_q.push_back(exp_v);
      if (is_d) run_txn(0, 1, wr, 32'h0, a, wd);
      else      run_txn(1, 0, 0, a, 32'h0, 32'h0);
      got_v   = is_d ? d_val : i_val;
      got_lat = is_d ? d_lat : i_lat;
      exp_v   = exp_q.pop_front();
      checks++; if (got_v !== exp_v) begin failures++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, got_v, exp_v); end
      checks++; if (got_lat !== lat) begin failures++; $display("FAIL rnd_lat t=%0d got=%0d exp=%0d", t, got_lat, lat); end
      checks++; if (ren_cyc + wen_cyc !== lat - 2 || (wr ? ren_cyc : wen_cyc) !== 0) begin failures++; $display("FAIL rnd_en t=%0d got ren=%0d wen=%0d exp total %0d", t, ren_cyc, wen_cyc, lat - 2); end
      checks++; if (addr_bad !== 0 || store_bad !== 0 || extra_hit !== 0) begin failures++; $display("FAIL rnd_bus t=%0d got addr=%0d store=%0d extra=%0d exp 0", t, addr_bad, store_bad, extra_hit); end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, err, exp_err); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ifetch();
    test_data_priority();
    test_write_busy();
    test_error_beat();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter and sequencer that sits between the CPU datapath (instruction fetch from the PC block, data port from the load/store path) and the shared unified RAM. It serializes instruction and data requests onto one RAM port, waits out RAM latency, and returns one-cycle hit pulses with registered load data. While an instruction fetch is outstanding it drives the stall that holds the PC register.

## Interface
- TIMEOUT, 64, max cycles a granted access may wait for RAM `ACCESS` before it is aborted
- BADWORD, 32'hBAD1BAD1, load value returned on an aborted or errored access
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request, level, held until `ihit`
- iaddr  in  32  instruction word address
- iload  out  32  fetched instruction, valid while `ihit`=1
- ihit  out  1  one-cycle instruction completion pulse
- dREN  in  1  data read request, level, held until `dhit`
- dWEN  in  1  data write request, level, held until `dhit`
- daddr  in  32  data word address
- dstore  in  32  write data
- dload  out  32  read data, valid while `dhit`=1
- dhit  out  1  one-cycle data completion pulse
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when `ramstate`=ACCESS
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR
- stall  out  1  PC hold: `iREN & ~ihit`
- err  out  1  sticky error flag; set on timeout or ERROR, cleared only by reset

## Operation
- FSM states: IDLE, DATA, INSTR, RESP.
- IDLE: if `dREN|dWEN` → latch op/addr/store data, go DATA; else if `iREN` → latch addr, go INSTR; else stay. Data beats instruction (data belongs to the instruction already in flight).
- `dREN` and `dWEN` both high: treated as write; no error.
- DATA/INSTR: `ramaddr`/`ramstore`/`ramREN`/`ramWEN` driven from latched registers only (never from live inputs). Cycle counter cleared on entry, increments each cycle.
- `ramstate`=ACCESS → capture `ramload` into `iload`/`dload` (write: `dload` ← 0), go RESP.
- `ramstate`=ERROR or counter reaches TIMEOUT-1 without ACCESS → load register ← BADWORD, set `err`, go RESP.
- FREE/BUSY → stay, keep enables asserted.
- RESP: pulse `dhit` or `ihit` (matching granted side) for exactly one cycle; RAM enables low; return to IDLE. No new grant taken in RESP.
- Requester must drop or change its request on the cycle after its hit; a request still high in IDLE is a new access.
- Address bits [1:0] passed through unchanged; no alignment check.

## Timing
- Reset (async): state IDLE; all outputs 0 (`ramaddr`, `ramstore`, `iload`, `dload`, counter, `err` = 0). Reset mid-access aborts it with no hit.
- Enables assert the cycle after grant; best-case latency request-high → hit = 3 cycles (grant, ACCESS, RESP) with ACCESS on first RAM cycle.
- N BUSY cycles add N cycles.
- Timeout: hit occurs TIMEOUT+1 cycles after grant.
- `stall` is combinational from `iREN` and registered `ihit`; low during `ihit` cycle so PC advances on that edge.
- Simultaneous `iREN` and `dREN` in IDLE: data completes first; instruction granted in the IDLE cycle after data RESP; `stall` stays high throughout.

## Structure
- `cpu_types_pkg`: add `ramstate_t` enum (FREE, BUSY, ACCESS, ERROR) if absent, `arb_state_t` (IDLE, DATA, INSTR, RESP), `word_t` reused; BADWORD constant lives there.
- New interface `ram_arbiter_if` with modports for cpu side, ram side, and arbiter.
- One sub-module natural: `arb_timer` (cycle counter with clear/enable and `expired` output at TIMEOUT-1).

## Test plan
- iREN=1, iaddr=0x40, RAM ACCESS first cycle with ramload=0x8C010004 → ihit on cycle 3, iload=0x8C010004, stall high cycles 1–2, low cycle 3.
- iREN=1 and dREN=1, daddr=0x100 (load 0x1234) → dhit first with dload=0x1234, then ihit; ramaddr never shows iaddr while DATA.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF, 3 BUSY cycles → ramWEN high 4 cycles with ramstore=0xDEADBEEF, dhit 6 cycles after request, dload=0.
- RAM stays BUSY forever, TIMEOUT=8 → ihit 9 cycles after grant, iload=0xBAD1BAD1, err=1 and stays 1.
- ramstate=ERROR on second RAM cycle → hit next cycle with BADWORD, err=1.
- nRST low during DATA with BUSY → all outputs 0 immediately, no dhit; after release, held dREN re-issues cleanly.
